// File: rtl/des_expand_keymix_if.sv
// Handshake bus for the DES expansion/key-mix stage: R/subkey in, tagged 48-bit S-box input out.
// master is the upstream/downstream environment, slave is the key-mix block itself.
interface des_expand_keymix_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:32] r_in;
    logic [1:48] subkey;
    logic        blk_start;
    logic        out_valid;
    logic        out_ready;
    logic [1:48] sbox_in;
    logic [3:0]  out_round;
    logic        out_last;

    modport master (
        output in_valid, r_in, subkey, blk_start, out_ready,
        input  in_ready, out_valid, sbox_in, out_round, out_last
    );

    modport slave (
        input  in_valid, r_in, subkey, blk_start, out_ready,
        output in_ready, out_valid, sbox_in, out_round, out_last
    );
endinterface

// File: rtl/des_expand_keymix.sv
// DES Feistel front end: E(R) ^ K into a small tagged FIFO feeding the eight S-boxes.
// All outputs are registers loaded from the next-state view of the FIFO.
module des_expand_keymix #(
    parameter int FIFO_DEPTH = 2,
    parameter int ROUNDS     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    des_expand_keymix_if.slave   bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [3:0]       LAST_TAG = 4'(ROUNDS - 1);

    // DES expansion permutation; bit 1 is the MSB on both sides.
    function automatic logic [1:48] expand_e(input logic [1:32] r);
        return {r[32], r[1:5],
                r[4:9], r[8:13], r[12:17], r[16:21], r[20:25], r[24:29],
                r[28:32], r[1]};
    endfunction

    function automatic logic [3:0] advance_tag(input logic [3:0] tag);
        return (tag == LAST_TAG) ? 4'd0 : (tag + 4'd1);
    endfunction

    logic [47:0]      mem_data_r [FIFO_DEPTH];
    logic [3:0]       mem_tag_r  [FIFO_DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [3:0]       round_ctr_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [47:0]      sbox_in_r;
    logic [3:0]       out_round_r;
    logic             out_last_r;

    logic             push_s;
    logic             pop_s;
    logic [3:0]       tag_s;
    logic [47:0]      entry_s;
    logic [CNT_W-1:0] count_next_s;
    logic [PTR_W-1:0] rd_next_s;
    logic [PTR_W-1:0] wr_next_s;
    logic [3:0]       round_next_s;
    logic [47:0]      head_data_s;
    logic [3:0]       head_tag_s;

    // Handshake decode, key mix, and next FIFO bookkeeping (flush wins over push/pop).
    always_comb begin
        push_s       = bus.in_valid & in_ready_r;
        pop_s        = out_valid_r & bus.out_ready;
        tag_s        = bus.blk_start ? 4'd0 : round_ctr_r;
        entry_s      = expand_e(bus.r_in) ^ bus.subkey;
        count_next_s = count_r;
        rd_next_s    = rd_ptr_r;
        wr_next_s    = wr_ptr_r;
        round_next_s = round_ctr_r;
        if (flush) begin
            count_next_s = CNT_ZERO;
            rd_next_s    = PTR_ZERO;
            wr_next_s    = PTR_ZERO;
            round_next_s = 4'd0;
        end else begin
            if (push_s) begin
                wr_next_s    = wr_ptr_r + PTR_ONE;
                round_next_s = advance_tag(tag_s);
            end else begin
                wr_next_s    = wr_ptr_r;
                round_next_s = round_ctr_r;
            end
            if (pop_s) begin
                rd_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_ONE;
                2'b01:   count_next_s = count_r - CNT_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Next head entry: the incoming word when the FIFO would otherwise be empty, else storage.
    always_comb begin
        head_data_s = 48'h0;
        head_tag_s  = 4'h0;
        if (count_next_s == CNT_ZERO) begin
            head_data_s = 48'h0;
            head_tag_s  = 4'h0;
        end else if ((count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s)) begin
            head_data_s = entry_s;
            head_tag_s  = tag_s;
        end else begin
            head_data_s = mem_data_r[rd_next_s];
            head_tag_s  = mem_tag_r[rd_next_s];
        end
    end

    // Control state and registered output view of the FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= CNT_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            wr_ptr_r    <= PTR_ZERO;
            round_ctr_r <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sbox_in_r   <= 48'h0;
            out_round_r <= 4'd0;
            out_last_r  <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            rd_ptr_r    <= rd_next_s;
            wr_ptr_r    <= wr_next_s;
            round_ctr_r <= round_next_s;
            in_ready_r  <= (count_next_s < DEPTH_C);
            out_valid_r <= (count_next_s != CNT_ZERO);
            sbox_in_r   <= head_data_s;
            out_round_r <= head_tag_s;
            out_last_r  <= (count_next_s != CNT_ZERO) && (head_tag_s == LAST_TAG);
        end
    end

    // Entry storage; written only on an accepted, non-flushed push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i] <= 48'h0;
                mem_tag_r[i]  <= 4'h0;
            end
        end else if (push_s && !flush) begin
            mem_data_r[wr_ptr_r] <= entry_s;
            mem_tag_r[wr_ptr_r]  <= tag_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sbox_in   = sbox_in_r;
    assign bus.out_round = out_round_r;
    assign bus.out_last  = out_last_r;
endmodule

// File: tb/tb_des_expand_keymix.sv
// Directed bench for des_expand_keymix: scoreboard queue filled on accepted pushes,
// head compared every cycle against an independent E-table model.
module tb_des_expand_keymix;
    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   failures;

    typedef struct {
        logic [47:0] d;
        logic [3:0]  t;
    } exp_t;

    exp_t       q[$];
    exp_t       ent;
    logic [3:0] mdl_round;
    logic [3:0] mtag;

    des_expand_keymix_if bus ();

    des_expand_keymix #(.FIFO_DEPTH(2), .ROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:48] model_e(input logic [1:32] r);
        logic [1:48] e;
        for (int i = 0; i < 48; i++) begin
            int s;
            s = 4 * (i / 6) + (i % 6);
            if (s == 0) s = 32;
            else if (s == 33) s = 1;
            e[i + 1] = r[s];
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: check head against queue front, then retire pops and record pushes.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", bus.in_ready, q.size() < 2);
            chk("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("sbox_in", bus.sbox_in, q[0].d);
                chk("out_round", bus.out_round, q[0].t);
                chk("out_last", bus.out_last, q[0].t == 4'd15);
            end else begin
                chk("empty_sbox", bus.sbox_in, 48'h0);
                chk("empty_round", {bus.out_round, bus.out_last}, 5'h0);
            end
            if (flush) begin
                q.delete();
                mdl_round = 4'd0;
            end else begin
                if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                    ent = q.pop_front();
                end
                if (bus.in_valid && bus.in_ready) begin
                    mtag  = bus.blk_start ? 4'd0 : mdl_round;
                    ent.d = model_e(bus.r_in) ^ bus.subkey;
                    ent.t = mtag;
                    q.push_back(ent);
                    mdl_round = (mtag == 4'd15) ? 4'd0 : mtag + 4'd1;
                end
            end
        end
    end

    task automatic push(input logic [31:0] r, input logic [47:0] k, input logic bs);
        bit ok;
        ok = 1'b0;
        bus.in_valid  = 1'b1;
        bus.r_in      = r;
        bus.subkey    = k;
        bus.blk_start = bs;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("push_accept", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.blk_start = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks        = 0;
        failures      = 0;
        mdl_round     = 4'd0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.r_in      = 32'h0;
        bus.subkey    = 48'h0;
        bus.blk_start = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sbox_in", bus.sbox_in, 48'h0);
        chk("rst_round_last", {bus.out_round, bus.out_last}, 5'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // 1: known DES vector
        bus.out_ready = 1'b1;
        push(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1);
        idle();
        @(negedge clk);
        chk("kv_sbox_in", bus.sbox_in, 48'h6117BA866527);
        chk("kv_round", bus.out_round, 4'd0);
        chk("kv_group1", bus.sbox_in[1:6], 6'b011000);
        drain();

        // 2: backpressure, C held off while full
        bus.out_ready = 1'b0;
        push(32'h12345678, 48'hA5A5A5A5A5A5, 1'b1);
        push(32'h9ABCDEF0, 48'h5A5A5A5A5A5A, 1'b0);
        bus.r_in   = 32'h0F0F0F0F;
        bus.subkey = 48'hFFFF0000FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_full", bus.in_ready, 1'b0);
        chk("bp_queue", q.size(), 2);
        bus.out_ready = 1'b1;
        push(32'h0F0F0F0F, 48'hFFFF0000FFFF, 1'b0);
        idle();
        drain();

        // 3: steady stream
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push($urandom, {$urandom, $urandom} & 48'hFFFFFFFFFFFF, 1'b0);
            chk("stream_cnt", q.size() <= 1, 1'b1);
        end
        idle();
        drain();

        // 4: round wrap over 17 pushes
        for (int i = 0; i < 17; i++) begin
            push($urandom, 48'h0000C0FFEE00 + 48'(i), i == 0);
        end
        idle();
        drain();

        // 5: blk_start mid-sequence
        for (int i = 0; i < 5; i++) begin
            push($urandom, 48'h13579BDF2468, 1'b0);
        end
        push(32'hDEADBEEF, 48'h0123456789AB, 1'b1);
        idle();
        @(negedge clk);
        chk("bs_tag0", bus.out_round, 4'd0);
        @(posedge clk);
        #1;
        push(32'hCAFEF00D, 48'hBA9876543210, 1'b0);
        idle();
        @(negedge clk);
        chk("bs_tag1", bus.out_round, 4'd1);
        drain();

        // 6a: flush with FIFO full and round counter at 7
        push(32'h11111111, 48'h111111111111, 1'b1);
        for (int i = 0; i < 4; i++) push($urandom, 48'h222222222222, 1'b0);
        idle();
        drain();
        bus.out_ready = 1'b0;
        push(32'h33333333, 48'h333333333333, 1'b0);
        push(32'h44444444, 48'h444444444444, 1'b0);
        idle();
        chk("f_full", bus.in_ready, 1'b0);
        chk("f_tail_tag", q[1].t, 4'd6);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("f_out_valid", bus.out_valid, 1'b0);
        chk("f_in_ready", bus.in_ready, 1'b1);
        push(32'h55555555, 48'h555555555555, 1'b0);
        idle();
        @(negedge clk);
        chk("f_next_tag", bus.out_round, 4'd0);
        drain();

        // 6b: asynchronous reset with FIFO full
        bus.out_ready = 1'b0;
        push(32'h66666666, 48'h666666666666, 1'b1);
        push(32'h77777777, 48'h777777777777, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        q.delete();
        mdl_round = 4'd0;
        #1;
        chk("ar_out_valid", bus.out_valid, 1'b0);
        chk("ar_sbox_in", bus.sbox_in, 48'h0);
        chk("ar_round_last", {bus.out_round, bus.out_last}, 5'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push(32'h88888888, 48'h888888888888, 1'b0);
        idle();
        @(negedge clk);
        chk("ar_next_tag", bus.out_round, 4'd0);
        drain();
        chk("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
